// File: rtl/if_id_stage.sv
// Fetch-to-decode stage: 2-entry skid buffer that slices decoded MIPS fields from the head entry.
// Optional perf counters (stall_cnt, flush_cnt) are built when IFID_PERF_CNT_EN is defined.
module if_id_stage #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic   main_valid, skid_valid;
  entry_t main_e, skid_e, in_e;
  logic   accept, deliver;

  assign in_e    = '{instr: in_instr, pc: in_pc};
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_e     <= '0;
      skid_e     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_e     <= in_e;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (accept && deliver) begin
        main_e <= in_e;
      end else if (accept) begin
        skid_e     <= in_e;
        skid_valid <= 1'b1;
      end else if (deliver) begin
        main_valid <= 1'b0;
      end
    end else if (deliver) begin
      // skid promotes to head so program order is kept
      main_e     <= skid_e;
      skid_valid <= 1'b0;
    end
  end

  // Outputs are masked while empty so nothing stale leaks downstream
  always_comb begin
    out_pc     = RESET_PC_TAG;
    out_opcode = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_rd     = '0;
    out_shamt  = '0;
    out_funct  = '0;
    out_imm    = '0;
    if (main_valid) begin
      out_pc     = main_e.pc;
      out_opcode = main_e.instr[31:26];
      out_rs     = main_e.instr[25:21];
      out_rt     = main_e.instr[20:16];
      out_rd     = main_e.instr[15:11];
      out_shamt  = main_e.instr[10:6];
      out_funct  = main_e.instr[5:0];
      out_imm    = main_e.instr[15:0];
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (main_valid || skid_valid) && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
